// File: rtl/scene_pixel_gen.sv
// Per-pixel colour source: platform map, 8x12 player sprite and a phase-accumulator tick generator.
// Optional SCENE_BORDER_EN draws a one-pixel 111 frame around the visible area.
module scene_pixel_gen #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] x_cord,
    input  logic [8:0] y_cord,
    input  logic [8:0] char_x,
    input  logic [8:0] char_y,
    input  logic [7:0] rate,
    output logic [2:0] bg_colour,
    output logic       solid,
    output logic [2:0] char_colour,
    output logic       tick
);

    localparam logic [2:0] COL_EMPTY  = 3'b000;
    localparam logic [2:0] COL_FLOOR  = 3'b010;
    localparam logic [2:0] COL_PLAT   = 3'b011;
    localparam logic [2:0] COL_BORDER = 3'b111;
    localparam logic [2:0] COL_HEAD   = 3'b110;
    localparam logic [2:0] COL_BODY   = 3'b100;
    localparam logic [2:0] COL_LEGS   = 3'b001;
    localparam logic [2:0] COL_CLEAR  = 3'b111;

    localparam logic [32:0] CLK_HZ_W = 33'(CLK_HZ);

    function automatic logic in_box(input logic [8:0] x, input logic [8:0] y,
                                    input int x0, input int x1, input int y0, input int y1);
        return (int'(x) >= x0) && (int'(x) <= x1) && (int'(y) >= y0) && (int'(y) <= y1);
    endfunction

    function automatic logic [2:0] bg_lookup(input logic [8:0] x, input logic [8:0] y);
        logic [2:0] col;
        col = COL_EMPTY;
        if ((int'(x) < SCREEN_W) && (int'(y) < SCREEN_H)) begin
`ifdef SCENE_BORDER_EN
            if ((int'(x) == 0) || (int'(x) == SCREEN_W - 1) ||
                (int'(y) == 0) || (int'(y) == SCREEN_H - 1))
                col = COL_BORDER;
            else
`endif
            if (in_box(x, y, 0, SCREEN_W - 1, 216, 239))
                col = COL_FLOOR;
            else if (in_box(x, y, 60, 139, 170, 177))
                col = COL_PLAT;
            else if (in_box(x, y, 180, 259, 130, 137))
                col = COL_PLAT;
            else if (in_box(x, y, 100, 179, 90, 97))
                col = COL_PLAT;
        end
        return col;
    endfunction

    // Offsets are 10-bit signed so an origin near 511 never aliases onto x/y 0.
    function automatic logic [2:0] sprite_lookup(input logic signed [9:0] dx,
                                                 input logic signed [9:0] dy);
        logic [2:0] col;
        col = COL_CLEAR;
        if ((dx >= 10'sd0) && (dx <= 10'sd7) && (dy >= 10'sd0) && (dy <= 10'sd11)) begin
            if (dy <= 10'sd3)
                col = COL_HEAD;
            else if (dy <= 10'sd8)
                col = COL_BODY;
            else if (dx[1] ^ dx[0])
                // dx in {1,2,5,6} are exactly the columns whose two low bits differ
                col = COL_LEGS;
        end
        return col;
    endfunction

    logic signed [9:0] dx_s;
    logic signed [9:0] dy_s;
    logic        [2:0] bg_nxt;
    logic        [2:0] char_nxt;
    logic       [32:0] acc_sum;
    logic              acc_wrap;
    logic       [31:0] acc_nxt;

    logic        [2:0] bg_colour_p0;
    logic              solid_p0;
    logic        [2:0] char_colour_p0;
    logic              tick_p0;
    logic       [31:0] acc_p0;

    always_comb begin
        dx_s     = $signed({1'b0, x_cord}) - $signed({1'b0, char_x});
        dy_s     = $signed({1'b0, y_cord}) - $signed({1'b0, char_y});
        bg_nxt   = bg_lookup(x_cord, y_cord);
        char_nxt = sprite_lookup(dx_s, dy_s);
        acc_sum  = {1'b0, acc_p0} + {25'd0, rate};
        acc_wrap = (acc_sum >= CLK_HZ_W);
        acc_nxt  = acc_wrap ? 32'(acc_sum - CLK_HZ_W) : acc_sum[31:0];
    end

    // Stage p0: registered lookups and limiter state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bg_colour_p0   <= COL_EMPTY;
            solid_p0       <= 1'b0;
            char_colour_p0 <= COL_CLEAR;
            tick_p0        <= 1'b0;
            acc_p0         <= 32'd0;
        end else begin
            bg_colour_p0   <= bg_nxt;
            solid_p0       <= (bg_nxt != COL_EMPTY);
            char_colour_p0 <= char_nxt;
            tick_p0        <= acc_wrap;
            acc_p0         <= acc_nxt;
        end
    end

    assign bg_colour   = bg_colour_p0;
    assign solid       = solid_p0;
    assign char_colour = char_colour_p0;
    assign tick        = tick_p0;

endmodule

// File: tb/tb_scene_pixel_gen.sv
// Randomized self-checking bench for scene_pixel_gen against a behavioural scene/tick model.
module tb_scene_pixel_gen;

    localparam int CLK_HZ = 1000;
    localparam int SW     = 320;
    localparam int SH     = 240;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] x_cord, y_cord, char_x, char_y;
    logic [7:0] rate;
    logic [2:0] bg_colour;
    logic       solid;
    logic [2:0] char_colour;
    logic       tick;

    int    chk_cnt = 0;
    int    err_cnt = 0;
    longint total  = 0;
    int    tick_cnt;
    int    consec_cnt;
    bit    prev_tick;

    scene_pixel_gen #(.CLK_HZ(CLK_HZ), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clock(clock), .reset(reset), .x_cord(x_cord), .y_cord(y_cord),
        .char_x(char_x), .char_y(char_y), .rate(rate),
        .bg_colour(bg_colour), .solid(solid), .char_colour(char_colour), .tick(tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_bg(input int x, input int y);
        if (x >= SW || y >= SH) return 0;
`ifdef SCENE_BORDER_EN
        if (x == 0 || x == SW - 1 || y == 0 || y == SH - 1) return 7;
`endif
        if (y >= 216 && y <= 239) return 2;
        if (x >= 60 && x <= 139 && y >= 170 && y <= 177) return 3;
        if (x >= 180 && x <= 259 && y >= 130 && y <= 137) return 3;
        if (x >= 100 && x <= 179 && y >= 90 && y <= 97) return 3;
        return 0;
    endfunction

    function automatic int m_char(input int x, input int y, input int cx, input int cy);
        int dx, dy;
        dx = x - cx;
        dy = y - cy;
        if (dx < 0 || dx > 7 || dy < 0 || dy > 11) return 7;
        if (dy <= 3) return 6;
        if (dy <= 8) return 4;
        if (dx == 1 || dx == 2 || dx == 5 || dx == 6) return 1;
        return 7;
    endfunction

    // One clock edge: model predicts from the applied inputs, outputs checked #1 after the edge.
    // The tick model counts how many whole CLK_HZ multiples the running sum of rates has crossed.
    task automatic step(input string tag);
        int     eb, ec;
        longint nt;
        bit     et;
        eb = m_bg(x_cord, y_cord);
        ec = m_char(x_cord, y_cord, char_x, char_y);
        nt = total + rate;
        et = (nt / CLK_HZ) != (total / CLK_HZ);
        @(posedge clock);
        #1;
        total = nt;
        check({tag, ".bg"}, bg_colour, eb);
        check({tag, ".solid"}, solid, (eb != 0));
        check({tag, ".char"}, char_colour, ec);
        check({tag, ".tick"}, tick, et);
        if (tick) tick_cnt++;
        if (tick && prev_tick) consec_cnt++;
        prev_tick = tick;
    endtask

    task automatic probe(input string tag, input int x, input int y);
        x_cord = 9'(x);
        y_cord = 9'(y);
        step(tag);
    endtask

    task automatic rand_pix();
        char_x = 9'($urandom_range(0, 511));
        char_y = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 1) == 1) begin
            x_cord = 9'(int'(char_x) + $urandom_range(0, 9) - 1);
            y_cord = 9'(int'(char_y) + $urandom_range(0, 13) - 1);
        end else begin
            x_cord = 9'($urandom_range(0, 511));
            y_cord = 9'($urandom_range(0, 260));
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, ".bg"}, bg_colour, 0);
        check({tag, ".solid"}, solid, 0);
        check({tag, ".char"}, char_colour, 7);
        check({tag, ".tick"}, tick, 0);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        x_cord = '0; y_cord = '0; char_x = '0; char_y = '0; rate = '0;
        prev_tick = 1'b0; tick_cnt = 0; consec_cnt = 0;
        #12;
        reset_check("rst_init");

        // First tick after the 10th edge at rate 100, then every 10 cycles
        rate  = 8'd100;
        reset = 1'b0;
        total = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step("tick100");
            if (tick) begin
                n = i;
                break;
            end
        end
        check("first_tick_edge", n, 10);
        tick_cnt = 0;
        for (int i = 0; i < 30; i++) step("tick100_run");
        check("tick100_count", tick_cnt, 3);

        rate = 8'd0;
        probe("map_platA", 150 - 10, 173);
        probe("map_platA2", 150, 173);
        probe("map_floor", 150, 220);
        probe("map_empty", 150, 150);
        probe("map_A_tl", 60, 170);
        probe("map_A_br", 139, 177);
        probe("map_A_left", 59, 170);
        probe("map_B", 200, 133);
        probe("map_C", 120, 95);
        probe("map_offx", 400, 220);
        probe("map_offy", 150, 250);
        probe("map_edge0", 0, 100);
        probe("map_edge_floor", 0, 220);
        probe("map_corner", SW - 1, SH - 1);

        char_x = 9'd35; char_y = 9'd205;
        probe("spr_head", 35, 205);
        probe("spr_body", 42, 210);
        probe("spr_leg", 36, 215);
        probe("spr_gap", 38, 215);
        probe("spr_right", 43, 205);
        probe("spr_below", 35, 217);

        char_x = 9'd510; char_y = 9'd0;
        probe("spr_wrapx", 2, 0);
        char_x = 9'd0; char_y = 9'd509;
        probe("spr_wrapy", 3, 1);

        // Asynchronous reset in the middle of a count
        rate = 8'd77;
        for (int i = 0; i < 23; i++) begin
            rand_pix();
            step("mid_run");
        end
        reset = 1'b1;
        #2;
        reset_check("rst_async");
        @(negedge clock);
        reset = 1'b0;
        total = 0;
        prev_tick = 1'b0;

        rate = 8'd0;
        tick_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            rand_pix();
            step("rate0");
        end
        check("rate0_ticks", tick_cnt, 0);

        rate = 8'd255;
        tick_cnt = 0;
        consec_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            rand_pix();
            step("rate255");
        end
        check("rate255_ticks", tick_cnt, 255);
        check("rate255_consec", consec_cnt, 0);

        consec_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) rate = 8'($urandom_range(0, 255));
            rand_pix();
            step("random");
        end
        check("random_consec", consec_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/scene_pixel_gen.md
Name: scene_pixel_gen

Overview:
- Per-pixel colour source for the platformer display path: sits between the raster scan counter and the VGA colour mux.
- Contains three sub-functions: a static platform map (background lookup), an 8x12 player sprite lookup positioned by a movable origin, and a rate limiter that emits a one-cycle tick at a programmable rate in Hz for game-logic updates.
- All lookups are registered with 1-cycle latency so the upstream scan counter and colour mux stay aligned.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz. Must be >= 256.
- SCREEN_W, 320, visible width; x range is 0..SCREEN_W-1.
- SCREEN_H, 240, visible height; y range is 0..SCREEN_H-1.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_cord  in  9  scan pixel x.
- y_cord  in  9  scan pixel y.
- char_x  in  9  sprite origin x (top-left corner).
- char_y  in  9  sprite origin y (top-left corner).
- rate  in  8  limiter tick rate in Hz; 0 = no ticks.
- bg_colour  out  3  platform colour at (x_cord,y_cord); 000 = empty.
- solid  out  1  high when bg_colour != 000; registered together with bg_colour.
- char_colour  out  3  sprite colour at (x_cord,y_cord); 111 = transparent.
- tick  out  1  one-cycle pulse at the programmed rate.

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-high.
- Reset values: bg_colour=000, solid=0, char_colour=111, tick=0, limiter accumulator=0.
- Latency: all outputs are registered. Inputs sampled at edge N appear on the outputs after edge N. No handshake.

Background map (priority top to bottom, first match wins; any pixel with x>=SCREEN_W or y>=SCREEN_H gives 000):
- floor: y 216..239, all x -> 010
- platform A: x 60..139, y 170..177 -> 011
- platform B: x 180..259, y 130..137 -> 011
- platform C: x 100..179, y 90..97 -> 011
- everything else -> 000

Sprite lookup:
- dx = x_cord - char_x and dy = y_cord - char_y, computed 10-bit signed with no 9-bit wrap.
- The pixel is inside the sprite only if 0<=dx<=7 and 0<=dy<=11. Outside -> 111.
- rows dy 0..3 -> 110 (head).
- rows dy 4..8 -> 100 (body).
- rows dy 9..11 -> 001 at dx 1,2,5,6 (legs); other dx in these rows -> 111.
- char_x/char_y near 511 must not wrap the sprite to x/y 0.

Limiter (phase accumulator):
- 32-bit acc. Each edge: if acc+rate >= CLK_HZ then acc <= acc+rate-CLK_HZ and tick <= 1; else acc <= acc+rate and tick <= 0.
- Average tick rate equals rate Hz exactly. tick is never high for two consecutive cycles, since rate <= 255 < CLK_HZ.
- rate=0: acc holds and tick stays 0.
- A change of rate takes effect on the next edge; acc is not cleared.
- Reset asserted mid-count clears acc immediately; counting restarts from 0 after release.

Optional Feature:
- Macro: SCENE_BORDER_EN.
- When defined: pixels with x==0, x==SCREEN_W-1, y==0 or y==SCREEN_H-1 return bg_colour 111 and solid 1. This rule has priority over the floor.
- When undefined: no border; the map above is unchanged, so x==0 at y 216..239 stays 010.

Test Plan:
- Reset value check: assert reset mid-run -> outputs immediately 000/0/111/0. Release reset with CLK_HZ=1000, rate=100 -> first tick high after the 10th edge, then every 10 cycles, width 1 cycle.
- Map probes: (150,173) -> 011/solid; (150,220) -> 010; (150,150) -> 000/solid 0; (60,170) and (139,177) -> 011; (59,170) -> 000. Each appears one cycle after the inputs are applied.
- Sprite probes with char=(35,205): (35,205) -> 110; (42,210) -> 100; (36,215) -> 001; (38,215) -> 111; (43,205) -> 111; (35,217) -> 111.
- Wrap check: char=(510,0), x_cord=2 -> 111 (no wrap-around).
- Rate edge cases: rate=0 for 5000 cycles -> no tick. rate=255 with CLK_HZ=1000 -> 255 ticks per 1000 cycles and never two consecutive.
- Border feature: with SCENE_BORDER_EN, (0,100) -> 111 and (0,220) -> 111. Without it, (0,220) -> 010.
